// File: rtl/multicycle_alu_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_alu_if : start/operand request and result bus of the ALU      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface multicycle_alu_if #(
  parameter int WIDTH = 4
);
  logic                 i_start;
  logic [WIDTH-1:0]     i_op1;
  logic [WIDTH-1:0]     i_op2;
  logic [2:0]           i_ctrl;
  logic                 o_busy;
  logic                 o_done;
  logic [2*WIDTH-1:0]   o_data;
  logic                 o_carry;
  logic                 o_zero;

  modport master (
    output i_start, i_op1, i_op2, i_ctrl,
    input  o_busy, o_done, o_data, o_carry, o_zero
  );

  modport slave (
    input  i_start, i_op1, i_op2, i_ctrl,
    output o_busy, o_done, o_data, o_carry, o_zero
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_alu.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_alu : single-cycle add/sub/logic, iterative shift-add multiply |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module multicycle_alu #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  multicycle_alu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]         state_q,  state_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [2*WIDTH-1:0] data_q,   data_d;
  logic               carry_q,  carry_d;
  logic               zero_q,   zero_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q,    cnt_d;

  logic [WIDTH:0]     w_ext1;
  logic [WIDTH:0]     w_ext2;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_alu_res;
  logic               w_alu_carry;
  logic [2*WIDTH-1:0] w_part_sum;

  // Zero-extended operands: bit WIDTH of the difference is the borrow-out.
  assign w_ext1     = {1'b0, bus.i_op1};
  assign w_ext2     = {1'b0, bus.i_op2};
  assign w_sum      = w_ext1 + w_ext2;
  assign w_diff     = w_ext1 - w_ext2;
  assign w_part_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    case (bus.i_ctrl)
      3'd0: begin
        w_alu_res   = {{(WIDTH-1){1'b0}}, w_sum};
        w_alu_carry = w_sum[WIDTH];
      end
      3'd1: begin
        w_alu_res   = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
        w_alu_carry = w_diff[WIDTH];
      end
      3'd3:    w_alu_res = {{WIDTH{1'b0}}, ~(bus.i_op1 & bus.i_op2)};
      3'd4:    w_alu_res = {{WIDTH{1'b0}}, ~(bus.i_op1 | bus.i_op2)};
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    data_d   = data_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_ctrl == 3'd2) begin
            state_d  = ST_MUL;
            busy_d   = 1'b1;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.i_op1};
            mplier_d = bus.i_op2;
            cnt_d    = '0;
          end else begin
            data_d  = w_alu_res;
            carry_d = w_alu_carry;
            zero_d  = (w_alu_res == '0);
            done_d  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        // One multiplier bit per edge; the last partial sum is the product.
        acc_d    = w_part_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          data_d  = w_part_sum;
          carry_d = 1'b0;
          zero_d  = (w_part_sum == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      data_q   <= data_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_data  = data_q;
  assign bus.o_carry = carry_q;
  assign bus.o_zero  = zero_q;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_alu : scoreboard bench for WIDTH=4 and WIDTH=8 instances    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_multicycle_alu;
  logic clk = 1'b0;
  logic rst_n;
  logic rst8_n;

  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(4)) bus4 ();
  multicycle_alu_if #(.WIDTH(8)) bus8 ();

  multicycle_alu #(.WIDTH(4)) u4 (.i_clk(clk), .i_rst_n(rst_n),  .bus(bus4));
  multicycle_alu #(.WIDTH(8)) u8 (.i_clk(clk), .i_rst_n(rst8_n), .bus(bus8));

  typedef struct {
    int     cyc;
    longint data;
    bit     carry;
  } exp_t;

  exp_t   q4[$];
  exp_t   q8[$];
  int     cyc    = 0;
  int     n_chk  = 0;
  int     n_fail = 0;

  // Reference model state for the WIDTH=4 instance
  int     nf4      = 0;
  int     mul_c4   = 0;
  bit     mul_act4 = 1'b0;
  bit     en4      = 1'b0;
  longint last_d4  = 0;
  bit     last_c4  = 1'b0;

  // Reference model state for the WIDTH=8 instance
  int     nf8      = 0;
  bit     en8      = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Result of one operation from the arithmetic definition of each opcode
  function automatic void ref_op(input int w, input int c, input longint a, input longint b,
                                 output longint d, output bit cy);
    longint mask;
    mask = (longint'(1) << w) - 1;
    d  = 0;
    cy = 1'b0;
    case (c)
      0: begin d = a + b;            cy = (a + b) > mask; end
      1: begin d = (a - b) & mask;   cy = (a < b);        end
      2: d = a * b;
      3: d = (~(a & b)) & mask;
      4: d = (~(a | b)) & mask;
      default: d = 0;
    endcase
  endfunction

  task automatic drive4(input bit st, input int c, input longint a, input longint b);
    exp_t   e;
    longint d;
    bit     cy;
    int     n;
    bus4.i_start = st;
    bus4.i_ctrl  = 3'(c);
    bus4.i_op1   = 4'(a);
    bus4.i_op2   = 4'(b);
    n = cyc + 1;
    if (st && n >= nf4) begin
      ref_op(4, c, a & 15, b & 15, d, cy);
      e.cyc   = n + ((c == 2) ? 4 : 0);
      e.data  = d;
      e.carry = cy;
      q4.push_back(e);
      if (c == 2) begin
        mul_act4 = 1'b1;
        mul_c4   = n;
        nf4      = n + 5;
      end else begin
        nf4 = n + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset4();
    rst_n        = 1'b0;
    bus4.i_start = 1'($urandom);
    bus4.i_ctrl  = 3'($urandom_range(0, 7));
    @(posedge clk);
    #1;
    q4.delete();
    last_d4      = 0;
    last_c4      = 1'b0;
    mul_act4     = 1'b0;
    nf4          = cyc + 1;
    rst_n        = 1'b1;
    bus4.i_start = 1'b0;
  endtask

  task automatic drive8(input bit st, input int c, input longint a, input longint b);
    exp_t   e;
    longint d;
    bit     cy;
    int     n;
    bus8.i_start = st;
    bus8.i_ctrl  = 3'(c);
    bus8.i_op1   = 8'(a);
    bus8.i_op2   = 8'(b);
    n = cyc + 1;
    if (st && n >= nf8) begin
      ref_op(8, c, a & 255, b & 255, d, cy);
      e.cyc   = n + ((c == 2) ? 8 : 0);
      e.data  = d;
      e.carry = cy;
      q8.push_back(e);
      nf8 = (c == 2) ? n + 9 : n + 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor for WIDTH=4: done timing, held result/flags, busy window
  always @(negedge clk) begin
    bit ed;
    bit eb;
    if (en4) begin
      ed = (q4.size() > 0) && (q4[0].cyc == cyc);
      n_chk++;
      if (bus4.o_done !== ed) begin
        n_fail++;
        $display("FAIL done4 cyc=%0d got=%b exp=%b", cyc, bus4.o_done, ed);
      end
      if (ed) begin
        last_d4 = q4[0].data;
        last_c4 = q4[0].carry;
        void'(q4.pop_front());
      end
      n_chk++;
      if (bus4.o_data !== 8'(last_d4) || bus4.o_carry !== last_c4 ||
          bus4.o_zero !== (last_d4 == 0)) begin
        n_fail++;
        $display("FAIL result4 cyc=%0d got data=%h carry=%b zero=%b exp data=%h carry=%b zero=%b",
                 cyc, bus4.o_data, bus4.o_carry, bus4.o_zero, 8'(last_d4), last_c4, (last_d4 == 0));
      end
      eb = mul_act4 && (cyc >= mul_c4) && (cyc < mul_c4 + 4);
      n_chk++;
      if (bus4.o_busy !== eb) begin
        n_fail++;
        $display("FAIL busy4 cyc=%0d got=%b exp=%b", cyc, bus4.o_busy, eb);
      end
    end
  end

  // Monitor for WIDTH=8: done timing and result at each completion
  always @(negedge clk) begin
    bit ed;
    if (en8) begin
      ed = (q8.size() > 0) && (q8[0].cyc == cyc);
      n_chk++;
      if (bus8.o_done !== ed) begin
        n_fail++;
        $display("FAIL done8 cyc=%0d got=%b exp=%b", cyc, bus8.o_done, ed);
      end
      if (ed) begin
        n_chk++;
        if (bus8.o_data !== 16'(q8[0].data) || bus8.o_carry !== q8[0].carry ||
            bus8.o_zero !== (q8[0].data == 0)) begin
          n_fail++;
          $display("FAIL result8 cyc=%0d got data=%h carry=%b exp data=%h carry=%b",
                   cyc, bus8.o_data, bus8.o_carry, 16'(q8[0].data), q8[0].carry);
        end
        void'(q8.pop_front());
      end
    end
  end

  initial begin
    rst8_n       = 1'b0;
    bus8.i_start = 1'b0;
    bus8.i_ctrl  = '0;
    bus8.i_op1   = '0;
    bus8.i_op2   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst8_n = 1'b1;
    en8    = 1'b1;
    drive8(1'b1, 2, 255, 255);
    repeat (8) drive8(1'b1, 0, $urandom_range(0, 255), 1);
    drive8(1'b1, 0, 200, 100);
    repeat (40) drive8($urandom_range(0, 2) != 0, $urandom_range(0, 7),
                       $urandom_range(0, 255), $urandom_range(0, 255));
    repeat (12) drive8(1'b0, 0, 0, 0);
  end

  initial begin
    rst_n        = 1'b0;
    bus4.i_start = 1'b0;
    bus4.i_ctrl  = '0;
    bus4.i_op1   = '0;
    bus4.i_op2   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en4   = 1'b1;
    drive4(1'b0, 0, 0, 0);

    drive4(1'b1, 0, 15, 1);
    drive4(1'b1, 1, 3, 5);
    drive4(1'b1, 1, 5, 5);
    drive4(1'b1, 2, 15, 15);
    repeat (4) drive4(1'b1, 0, $urandom_range(0, 15), 3);
    drive4(1'b1, 3, 10, 12);
    drive4(1'b1, 4, 10, 12);
    drive4(1'b1, 6, 9, 9);
    drive4(1'b1, 2, 3, 7);
    drive4(1'b0, 0, 0, 0);
    reset4();
    drive4(1'b1, 0, 2, 2);

    repeat (400) begin
      if ($urandom_range(0, 39) == 0) reset4();
      else drive4($urandom_range(0, 2) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 15), $urandom_range(0, 15));
    end
    repeat (8) drive4(1'b0, 0, 0, 0);

    n_chk++;
    if (q4.size() != 0) begin
      n_fail++;
      $display("FAIL drain4 got=%0d pending exp=0", q4.size());
    end
    n_chk++;
    if (q8.size() != 0) begin
      n_fail++;
      $display("FAIL drain8 got=%0d pending exp=0", q8.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal values 2..16.
REQ-002 Port: i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: i_rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: i_start  input  1  request to start an operation; sampled each rising edge.
REQ-005 Port: i_op1  input  WIDTH  first operand, unsigned.
REQ-006 Port: i_op2  input  WIDTH  second operand, unsigned.
REQ-007 Port: i_ctrl  input  3  opcode: 0 add, 1 sub, 2 mul, 3 nand, 4 nor, 5-7 zero.
REQ-008 Port: o_busy  output  1  high while a multiply is in progress; starts are ignored while high.
REQ-009 Port: o_done  output  1  one-cycle pulse; o_data, o_carry and o_zero are updated in this cycle.
REQ-010 Port: o_data  output  2*WIDTH  result register.
REQ-011 Port: o_carry  output  1  add carry-out, or sub borrow-out.
REQ-012 Port: o_zero  output  1  high when o_data equals 0.

Function
REQ-013 Accept: the block SHALL accept a start at rising edge E when i_rst_n=1, i_start=1 and the state is IDLE.
REQ-014 Latching: at E the block SHALL latch i_op1, i_op2 and i_ctrl; later changes to these inputs SHALL NOT affect the operation in progress.
REQ-015 States: the block SHALL have two states, IDLE and MUL.
REQ-016 Transitions: IDLE->MUL on an accepted start with i_ctrl=2; MUL->IDLE at the edge that completes the multiply; all other accepted starts keep the state at IDLE.
REQ-017 Latency, non-multiply: for opcodes other than 2, the block SHALL update the result at edge E and drive o_done=1 for the cycle E..E+1.
REQ-018 Multiply algorithm: the block SHALL use an iterative shift-add, one partial product per edge.
REQ-019 Multiply timing: o_busy SHALL be 1 from E to E+WIDTH; at E+WIDTH the block SHALL write the product and drive o_done=1 for the cycle E+WIDTH..E+WIDTH+1, with o_busy=0 in that cycle.
REQ-020 Busy: i_start SHALL be ignored while o_busy=1; it SHALL NOT be queued.
REQ-021 Back-to-back: an i_start present during an o_done cycle SHALL be accepted.
REQ-022 Add: o_data[WIDTH:0] = i_op1 + i_op2, upper bits 0, o_carry = bit WIDTH of the sum.
REQ-023 Sub: o_data[WIDTH-1:0] = (i_op1 - i_op2) mod 2^WIDTH, upper bits 0, o_carry = 1 when i_op1 < i_op2.
REQ-024 Mul: o_data = full 2*WIDTH-bit unsigned product, o_carry = 0.
REQ-025 Nand/nor: o_data[WIDTH-1:0] = bitwise ~(op1&op2) or ~(op1|op2), upper bits 0, o_carry = 0.
REQ-026 Opcodes 5-7: o_data = 0, o_carry = 0, o_done still pulses with 1-cycle latency.
REQ-027 Zero flag: o_zero SHALL be registered with o_data and equal (o_data == 0).
REQ-028 Hold: o_data, o_carry and o_zero SHALL hold their values between completions.
REQ-029 Done: o_done SHALL be 0 in every cycle that is not a completion cycle.

Reset
REQ-030 Reset action: at a rising edge with i_rst_n=0 the block SHALL set state IDLE, o_busy=0, o_done=0, o_data=0, o_carry=0, o_zero=1.
REQ-031 Reset priority: reset SHALL override i_start sampled at the same edge.
REQ-032 Mid-operation reset: reset during MUL SHALL abort the multiply, with no o_done pulse and no result update.
REQ-033 Asynchrony: assertion of i_rst_n between clock edges SHALL have no effect until the next rising edge.

Verification (WIDTH=4 unless stated)
REQ-034 Add: add 4'hF+4'h1 -> next cycle o_done=1, o_data=8'h10, o_carry=1, o_zero=0.
REQ-035 Sub: sub 3-5 -> o_data=8'h0E, o_carry=1; then sub 5-5 -> o_data=0, o_carry=0, o_zero=1.
REQ-036 Multiply: mul 15*15 -> o_busy high 4 cycles; o_done at E+4 with o_data=8'hE1; i_op1 changed and i_start pulsed mid-operation -> no effect.
REQ-037 Logic ops and unused opcode: nand 4'hA,4'hC -> 8'h07; nor 4'hA,4'hC -> 8'h01; i_ctrl=6 -> o_data=0, o_zero=1.
REQ-038 Reset mid-multiply: i_rst_n=0 at E+2 of a mul -> all outputs at reset values, no o_done; next add 2+2 -> 8'h04.
REQ-039 Wide multiply and chaining: WIDTH=8, mul 255*255 -> o_data=16'hFE01 after 8 cycles; start in the done cycle accepted.
